// File: rtl/crc_stream_engine.sv
// Streaming CRC generator/checker: forwards beats with one cycle of latency,
// appends the CRC in generate mode and judges the residue in check mode.
module crc_stream_engine #(
  parameter int               DATA_W  = 8,
  parameter int               CRC_W   = 32,
  parameter logic [CRC_W-1:0] POLY    = 32'h04C11DB7,
  parameter logic [CRC_W-1:0] INIT    = '1,
  parameter logic [CRC_W-1:0] XOROUT  = '1,
  parameter bit               REFIN   = 1'b1,
  parameter bit               REFOUT  = 1'b1,
  parameter logic [CRC_W-1:0] RESIDUE = 32'hDEBB20E3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              mode,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  input  logic              in_last,
  output logic              in_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  output logic              out_last,
  input  logic              out_ready,
  output logic [CRC_W-1:0]  crc_out,
  output logic              done,
  output logic              crc_ok,
  output logic [1:0]        dbg_state_o
);

  typedef enum logic [1:0] {IDLE = 2'd0, DATA = 2'd1, APPEND = 2'd2} state_t;

  localparam int NB    = CRC_W / DATA_W;
  localparam int CNT_W = $clog2(NB + 1);

  function automatic logic [CRC_W-1:0] reflect_crc(input logic [CRC_W-1:0] v);
    logic [CRC_W-1:0] r;
    for (int i = 0; i < CRC_W; i++) r[i] = v[CRC_W-1-i];
    return r;
  endfunction

  // With REFIN the register is kept in reflected orientation (shift right),
  // which is the orientation RESIDUE is expressed in.
  localparam logic [CRC_W-1:0] POLY_R = reflect_crc(POLY);
  localparam logic [CRC_W-1:0] SEED   = REFIN ? reflect_crc(INIT) : INIT;

  function automatic logic [CRC_W-1:0] crc_step(input logic [CRC_W-1:0] c_in,
                                                input logic [DATA_W-1:0] d);
    logic [CRC_W-1:0] c;
    logic [7:0]       byt;
    logic             fb;
    c = c_in;
    for (int b = 0; b < DATA_W / 8; b++) begin
      byt = d[8*b +: 8];
      for (int i = 0; i < 8; i++) begin
        if (REFIN) begin
          fb = c[0] ^ byt[i];
          c  = c >> 1;
          if (fb) c = c ^ POLY_R;
        end else begin
          fb = c[CRC_W-1] ^ byt[7-i];
          c  = c << 1;
          if (fb) c = c ^ POLY;
        end
      end
    end
    return c;
  endfunction

  function automatic logic [CRC_W-1:0] crc_final(input logic [CRC_W-1:0] c);
    return ((REFIN != REFOUT) ? reflect_crc(c) : c) ^ XOROUT;
  endfunction

  state_t             state_q, state_d;
  logic [CRC_W-1:0]   crc_q, crc_d;
  logic               mode_q, mode_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [DATA_W-1:0]  out_data_q, out_data_d;
  logic               out_valid_q, out_valid_d;
  logic               out_last_q, out_last_d;
  logic               done_q, done_d;
  logic [CRC_W-1:0]   crc_out_q, crc_out_d;
  logic               crc_ok_q, crc_ok_d;

  // Handshake: a beat moves on a port in any cycle where its valid and ready
  // are both high at the rising edge; a presented output beat holds until taken.
  logic             out_fire, out_free, in_fire, frame_mode;
  logic [CRC_W-1:0] crc_next, fin_now, app_word;

  assign out_fire = out_valid_q & out_ready;
  assign out_free = ~out_valid_q | out_ready;
  assign in_ready = rst_n & ~clr & out_free & ((state_q == IDLE) | (state_q == DATA));
  assign in_fire  = in_valid & in_ready;
  assign crc_next = crc_step((state_q == IDLE) ? SEED : crc_q, in_data);
  assign fin_now  = crc_final(crc_q);
  assign app_word = fin_now >> (DATA_W * int'(cnt_q));

  always_comb begin
    state_d     = state_q;
    crc_d       = crc_q;
    mode_d      = mode_q;
    cnt_d       = cnt_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    done_d      = 1'b0;
    crc_out_d   = crc_out_q;
    crc_ok_d    = crc_ok_q;
    frame_mode  = (state_q == IDLE) ? mode : mode_q;
    if (out_fire) begin
      out_valid_d = 1'b0;
      out_last_d  = 1'b0;
    end
    if (clr) begin
      state_d     = IDLE;
      crc_d       = SEED;
      out_valid_d = 1'b0;
      out_last_d  = 1'b0;
    end else begin
      case (state_q)
        IDLE, DATA: begin
          if (in_fire) begin
            mode_d      = frame_mode;
            crc_d       = crc_next;
            out_data_d  = in_data;
            out_valid_d = 1'b1;
            out_last_d  = frame_mode & in_last;
            state_d     = DATA;
            if (in_last) begin
              if (frame_mode) begin
                state_d   = IDLE;
                done_d    = 1'b1;
                crc_ok_d  = (crc_next == RESIDUE);
                crc_out_d = crc_final(crc_next);
              end else begin
                state_d = APPEND;
                cnt_d   = '0;
              end
            end
          end
        end
        APPEND: begin
          if (out_fire && out_last_q) begin
            state_d   = IDLE;
            done_d    = 1'b1;
            crc_ok_d  = 1'b1;
            crc_out_d = fin_now;
          end else if (out_free && (cnt_q != CNT_W'(NB))) begin
            out_data_d  = app_word[DATA_W-1:0];
            out_valid_d = 1'b1;
            out_last_d  = (cnt_q == CNT_W'(NB - 1));
            cnt_d       = cnt_q + 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      crc_q       <= SEED;
      mode_q      <= 1'b0;
      cnt_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      done_q      <= 1'b0;
      crc_out_q   <= '0;
      crc_ok_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      crc_q       <= crc_d;
      mode_q      <= mode_d;
      cnt_q       <= cnt_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      done_q      <= done_d;
      crc_out_q   <= crc_out_d;
      crc_ok_q    <= crc_ok_d;
    end
  end

  assign out_data    = out_data_q;
  assign out_valid   = out_valid_q;
  assign out_last    = out_last_q;
  assign done        = done_q;
  assign crc_out     = crc_out_q;
  assign crc_ok      = crc_ok_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_crc_stream_engine.sv
// Scoreboarded bench for crc_stream_engine: byte-wide instance under random
// frames and back-pressure, plus a 32-bit-beat instance cross-checked on CRC.
module tb_crc_stream_engine;

  typedef logic [7:0] bq_t[$];

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clr = 1'b0;
  logic        mode = 1'b0;
  logic [7:0]  in_data = '0;
  logic        in_valid = 1'b0;
  logic        in_last = 1'b0;
  logic        in_ready;
  logic [7:0]  out_data;
  logic        out_valid, out_last;
  logic        out_ready = 1'b1;
  logic [31:0] crc_out;
  logic        done, crc_ok;
  logic [1:0]  dbg_state;

  logic [31:0] w_in_data = '0;
  logic        w_in_valid = 1'b0;
  logic        w_in_last = 1'b0;
  logic        w_in_ready;
  logic [31:0] w_out_data;
  logic        w_out_valid, w_out_last;
  logic [31:0] w_crc_out;
  logic        w_done, w_crc_ok;
  logic [1:0]  w_dbg_state;

  int          checks = 0;
  int          errors = 0;
  logic [8:0]  exp_q[$];
  logic [32:0] exp_done_q[$];
  logic [32:0] held = '0;
  bit          rand_ready = 1'b0;
  int          w_beats = 0;
  logic [31:0] w_last_beat = '0;

  crc_stream_engine u_dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .mode(mode),
    .in_data(in_data), .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_last(out_last), .out_ready(out_ready),
    .crc_out(crc_out), .done(done), .crc_ok(crc_ok), .dbg_state_o(dbg_state)
  );

  crc_stream_engine #(.DATA_W(32)) u_dut32 (
    .clk(clk), .rst_n(rst_n), .clr(1'b0), .mode(1'b0),
    .in_data(w_in_data), .in_valid(w_in_valid), .in_last(w_in_last), .in_ready(w_in_ready),
    .out_data(w_out_data), .out_valid(w_out_valid), .out_last(w_out_last), .out_ready(1'b1),
    .crc_out(w_crc_out), .done(w_done), .crc_ok(w_crc_ok), .dbg_state_o(w_dbg_state)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference CRC-32 (reflected, init/xorout all-ones) over a byte list.
  function automatic logic [31:0] model_crc(input bq_t b);
    logic [31:0] c;
    c = 32'hFFFF_FFFF;
    foreach (b[k]) begin
      c = c ^ {24'h0, b[k]};
      repeat (8) c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
    end
    return ~c;
  endfunction

  // back-pressure generator
  initial forever begin
    @(posedge clk); #1;
    out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // monitor / scoreboard
  logic       hold_pend = 1'b0;
  logic [8:0] hold_val = '0;
  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      hold_pend = 1'b0;
    end else begin
      if (hold_pend) begin
        chk("hold_valid", 64'(out_valid), 64'd1);
        chk("hold_beat", 64'({out_last, out_data}), 64'(hold_val));
      end
      hold_pend = out_valid && !out_ready;
      hold_val  = {out_last, out_data};
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL out_unexpected: got beat %0h with nothing expected", {out_last, out_data});
        end else begin
          chk("out_beat", 64'({out_last, out_data}), 64'(exp_q.pop_front()));
        end
      end
      if (done) begin
        if (exp_done_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL done_unexpected: got crc %0h ok %0b with no frame pending", crc_out, crc_ok);
        end else begin
          held = exp_done_q.pop_front();
          chk("done_crc", 64'(crc_out), 64'(held[31:0]));
          chk("done_ok", 64'(crc_ok), 64'(held[32]));
        end
      end else begin
        chk("result_hold", 64'({crc_ok, crc_out}), 64'(held));
      end
      if (w_out_valid) begin
        w_beats++;
        if (w_out_last) w_last_beat = w_out_data;
      end
    end
  end

  // driver tasks
  task automatic send_frame(input bq_t fr, input bit m, input int stop_at);
    int          n;
    int          t;
    bit          acc;
    logic [31:0] c;
    n = fr.size();
    for (int k = 0; k < n && k < stop_at; k++) begin
      in_valid = 1'b1;
      in_data  = fr[k];
      in_last  = (k == n - 1) && (stop_at >= n);
      mode     = (k == 0) ? m : 1'($urandom_range(0, 1));
      acc = 1'b0;
      t   = 0;
      while (!acc && t < 300) begin
        @(negedge clk);
        acc = in_ready;
        @(posedge clk); #1;
        t++;
      end
      if (!acc) begin
        checks++; errors++;
        $display("FAIL in_accept: beat %0d never accepted (got in_ready 0, required 1)", k);
      end else begin
        exp_q.push_back({m & in_last, fr[k]});
        if (in_last) begin
          c = model_crc(fr);
          if (!m) begin
            for (int i = 0; i < 4; i++) exp_q.push_back({(i == 3), c[8*i +: 8]});
            exp_done_q.push_back({1'b1, c});
          end else begin
            exp_done_q.push_back({((c ^ 32'hFFFF_FFFF) == 32'hDEBB_20E3), c});
            in_valid = 1'b0;
            @(negedge clk);
            chk("check_done_timing", 64'(done), 64'd1);
            @(posedge clk); #1;
          end
        end
      end
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    while ((exp_q.size() != 0 || exp_done_q.size() != 0) && t < 1000) begin
      @(posedge clk); #1;
      t++;
    end
    if (t >= 1000) begin
      checks++; errors++;
      $display("FAIL drain: %0d beats and %0d results still expected (required 0)",
               exp_q.size(), exp_done_q.size());
      exp_q.delete();
      exp_done_q.delete();
    end
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic apply_reset(input int cyc);
    rst_n = 1'b0;
    for (int i = 0; i < cyc; i++) begin
      @(posedge clk);
      @(negedge clk);
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_out_last", 64'(out_last), 64'd0);
      chk("rst_out_data", 64'(out_data), 64'd0);
      chk("rst_done", 64'(done), 64'd0);
      chk("rst_crc_ok", 64'(crc_ok), 64'd0);
      chk("rst_crc_out", 64'(crc_out), 64'd0);
      chk("rst_in_ready", 64'(in_ready), 64'd0);
      chk("rst_state", 64'(dbg_state), 64'd0);
      chk("rst_state32", 64'(w_dbg_state), 64'd0);
    end
    held  = '0;
    rst_n = 1'b1;
    #1;
    chk("in_ready_after_reset", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
  endtask

  task automatic pulse_clr();
    clr = 1'b1;
    @(negedge clk);
    chk("in_ready_during_clr", 64'(in_ready), 64'd0);
    @(posedge clk); #1;
    clr = 1'b0;
  endtask

  // stimulus
  bq_t         ref9, good, bad, fr;
  bit          m;
  int          n, t;
  logic [31:0] c;
  initial begin
    for (int i = 0; i < 9; i++) ref9.push_back(8'(32'h31 + i));
    good = ref9;
    good.push_back(8'h26); good.push_back(8'h39); good.push_back(8'hF4); good.push_back(8'hCB);
    bad = good;
    bad[4] = 8'h36;

    apply_reset(2);

    send_frame(ref9, 1'b0, 99);
    wait_drain();
    chk("gen_crc_out", 64'(crc_out), 64'hCBF4_3926);
    chk("gen_crc_ok", 64'(crc_ok), 64'd1);

    send_frame(good, 1'b1, 99);
    wait_drain();
    chk("check_good_ok", 64'(crc_ok), 64'd1);
    send_frame(bad, 1'b1, 99);
    wait_drain();
    chk("check_bad_ok", 64'(crc_ok), 64'd0);

    rand_ready = 1'b1;
    send_frame(ref9, 1'b0, 99);
    wait_drain();
    chk("gen_bp_crc_out", 64'(crc_out), 64'hCBF4_3926);
    rand_ready = 1'b0;
    idle(2);

    send_frame(ref9, 1'b0, 4);
    idle(3);
    pulse_clr();
    send_frame(ref9, 1'b0, 99);
    wait_drain();
    chk("clr_then_gen_crc", 64'(crc_out), 64'hCBF4_3926);

    send_frame(ref9, 1'b0, 3);
    idle(3);
    apply_reset(2);
    send_frame(ref9, 1'b0, 99);
    wait_drain();
    chk("reset_then_gen_crc", 64'(crc_out), 64'hCBF4_3926);

    fr.delete();
    repeat (16) fr.push_back(8'h61);
    send_frame(fr, 1'b0, 99);
    wait_drain();
    w_beats = 0;
    for (int k = 0; k < 4; k++) begin
      w_in_valid = 1'b1;
      w_in_data  = 32'h6161_6161;
      w_in_last  = (k == 3);
      t = 0;
      while (!w_in_ready && t < 100) begin @(posedge clk); #1; t++; end
      @(posedge clk); #1;
    end
    w_in_valid = 1'b0;
    w_in_last  = 1'b0;
    t = 0;
    while (!w_done && t < 100) begin @(negedge clk); t++; end
    chk("w32_done_seen", 64'(w_done), 64'd1);
    chk("w32_crc_out", 64'(w_crc_out), 64'(model_crc(fr)));
    chk("w32_crc_ok", 64'(w_crc_ok), 64'd1);
    chk("w32_crc_matches_w8", 64'(w_crc_out), 64'(crc_out));
    @(posedge clk); #1;
    chk("w32_beats", 64'(w_beats), 64'd5);
    chk("w32_append_beat", 64'(w_last_beat), 64'(model_crc(fr)));

    rand_ready = 1'b1;
    for (int f = 0; f < 30; f++) begin
      fr.delete();
      m = 1'($urandom_range(0, 1));
      if (!m) begin
        n = $urandom_range(1, 10);
        repeat (n) fr.push_back(8'($urandom_range(0, 255)));
      end else begin
        n = $urandom_range(0, 8);
        repeat (n) fr.push_back(8'($urandom_range(0, 255)));
        if (n == 0) begin
          fr.push_back(8'($urandom_range(0, 255)));
        end else begin
          c = model_crc(fr);
          for (int i = 0; i < 4; i++) fr.push_back(c[8*i +: 8]);
          if ($urandom_range(0, 2) == 0)
            fr[$urandom_range(0, n + 3)] ^= 8'(1 << $urandom_range(0, 7));
        end
      end
      send_frame(fr, m, 99);
    end
    wait_drain();
    rand_ready = 1'b0;

    chk("beats_left", 64'(exp_q.size()), 64'd0);
    chk("results_left", 64'(exp_done_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/crc_stream_engine.md
CRC_STREAM_ENGINE -- requirements
Module: crc_stream_engine

Interface
REQ-001 The module SHALL have parameter DATA_W, default 8, giving the stream beat width in bits (8, 16 or 32).
REQ-002 The module SHALL have parameter CRC_W, default 32, giving the CRC width in bits (a multiple of DATA_W).
REQ-003 The module SHALL have parameter POLY, default 32'h04C11DB7, giving the generator polynomial in normal form.
REQ-004 The module SHALL have parameters INIT, default all-ones, and XOROUT, default all-ones, giving the register preset and the final XOR.
REQ-005 The module SHALL have parameters REFIN, default 1, and REFOUT, default 1, selecting per-byte input reflection and output reflection.
REQ-006 The module SHALL have parameter RESIDUE, default 32'hDEBB20E3, giving the raw-register value that marks a good frame in check mode.
REQ-007 The module SHALL have ports, in order: clk in 1, clock; rst_n in 1, reset; clr in 1, frame abort; mode in 1, 0=generate 1=check.
REQ-008 The module SHALL have ports: in_data in DATA_W; in_valid in 1; in_last in 1, final beat of frame; in_ready out 1.
REQ-009 The module SHALL have ports: out_data out DATA_W; out_valid out 1; out_last out 1; out_ready in 1.
REQ-010 The module SHALL have ports: crc_out out CRC_W, final CRC; done out 1, one-cycle frame-complete pulse; crc_ok out 1, check result.
REQ-011 The module SHALL use one clock, clk, with all state updated on its rising edge, and rst_n SHALL be a synchronous, active-low reset.

Function
REQ-012 The module SHALL implement an FSM with states IDLE, DATA and APPEND.
REQ-013 A beat SHALL transfer on the input when in_valid and in_ready are both high, and on the output when out_valid and out_ready are both high.
REQ-014 in_ready SHALL be high only in IDLE or DATA, with clr low, and with out_valid low or out_ready high.
REQ-015 The first beat accepted in IDLE SHALL latch mode for the frame and seed the CRC register with INIT; mode changes mid-frame SHALL be ignored.
REQ-016 Each accepted beat SHALL update the CRC register over all DATA_W bits in one cycle, processing bytes LSB-byte first and bits reflected when REFIN=1.
REQ-017 Each accepted beat SHALL appear on out_data with out_valid high exactly one cycle later (registered, 1-cycle latency), unchanged.
REQ-018 Generate mode SHALL forward the in_last beat with out_last low, then enter APPEND.
REQ-019 In APPEND, the module SHALL emit CRC_W/DATA_W beats of the final CRC (reflected per REFOUT, XORed with XOROUT), least-significant DATA_W first, with out_last high only on the final beat.
REQ-020 Generate mode SHALL pulse done and return to IDLE in the cycle after the final APPEND beat is transferred.
REQ-021 Check mode SHALL forward all beats, including the trailing CRC, with out_last copied from in_last, and SHALL never enter APPEND.
REQ-022 Check mode SHALL pulse done in the cycle after the in_last beat is accepted, with crc_ok = (raw CRC register == RESIDUE).
REQ-023 crc_out SHALL update to the final CRC (post-REFOUT/XOROUT) at done and hold until the next done or reset.
REQ-024 crc_ok SHALL update at done and hold until the next done; in generate mode crc_ok SHALL be set to 1.
REQ-025 A single-beat frame (in_last on the first beat) SHALL be legal in both modes, going IDLE->APPEND in generate mode or staying IDLE in check mode.
REQ-026 While out_ready is low, out_data, out_valid and out_last SHALL hold stable and no new input beat SHALL be accepted.
REQ-027 clr SHALL take priority over in_valid: the FSM returns to IDLE, the CRC register is preset to INIT, any pending output beat is dropped, done is not pulsed, and crc_out and crc_ok are retained.
REQ-028 Back-to-back frames SHALL be supported, with a new frame's first beat acceptable in the cycle after the IDLE return.

Reset
REQ-029 While rst_n is low at a clk edge, the module SHALL force: state IDLE, CRC register INIT, out_valid 0, out_last 0, out_data 0, done 0, crc_ok 0, crc_out 0 and in_ready 0.
REQ-030 A reset mid-frame SHALL discard the frame without a done pulse, and in_ready SHALL rise in the first cycle after rst_n goes high.

Verification
REQ-031 Generate, defaults: bytes 31..39, out_ready held 1 -> output bytes 31..39, 26, 39, F4, CB with out_last on CB; crc_out=32'hCBF43926, done one pulse.
REQ-032 Check, defaults: bytes 31..39, 26, 39, F4, CB -> done pulse one cycle after CB is accepted, crc_ok=1; flipping byte 35 to 36 -> crc_ok=0.
REQ-033 Generate with out_ready toggled randomly (50%) -> output sequence and crc_out identical to REQ-031, with no beat lost or duplicated.
REQ-034 Generate with clr asserted after byte 34 is accepted, then a fresh 31..39 frame -> no done for the aborted frame; the second frame yields crc_out=32'hCBF43926.
REQ-035 DATA_W=32, generate: beats 34333231, 38373635, then single-byte frame not applicable -> instead 9-byte-equivalent test with DATA_W=8 reused; for DATA_W=32 feed 4 beats of 32'h61616161 and compare crc_out against the DATA_W=8 instance fed the same 16 bytes -> equal.
REQ-036 rst_n low for 2 cycles mid-frame, then frame 31..39 -> all outputs at reset values during reset; the following frame produces crc_out=32'hCBF43926.
